n64_joybus_device: RTL and testbench
====================================

N64_JOYBUS_DEVICE -- requirements
Module: n64_joybus_device

Interface
REQ-001 SHALL have parameter US_TICKS, default 50, meaning clk cycles per 1 us.
REQ-002 SHALL have parameter IDLE_US, default 8, meaning the high time in us that aborts a partial frame.
REQ-003 SHALL have port clk  in  1  system clock; one clock domain only.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port joy_in  in  1  raw joybus line level, asynchronous.
REQ-006 SHALL have port joy_oe  out  1  drive line low when 1; line released (open-drain) when 0.
REQ-007 SHALL have port buttons  in  16  button word, MSB first on wire.
REQ-008 SHALL have port stick_x  in  8  signed X axis.
REQ-009 SHALL have port stick_y  in  8  signed Y axis.
REQ-010 SHALL have port poll_strobe  out  1  one-cycle pulse when the 0x01 reply snapshot is taken.
REQ-011 SHALL have port reset_cmd  out  1  one-cycle pulse on an accepted 0xFF command.
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL pass joy_in through a 2-flop synchronizer before use; all timing counts from the synchronized level.
REQ-014 SHALL implement states IDLE, RX_LOW, RX_HIGH, RX_STOP, TURN, TX_LOW, TX_HIGH, TX_STOP, WAIT_IDLE.
REQ-015 IDLE: a falling edge SHALL go to RX_LOW and clear the bit timer.
REQ-016 RX data bit SHALL be decoded as 1 if the line is high at 2*US_TICKS after the falling edge, else 0; bits are MSB first into an 8-bit command register.
REQ-017 A low time above 5*US_TICKS SHALL abort to WAIT_IDLE.
REQ-018 A high time above IDLE_US*US_TICKS before 8 bits are received SHALL abort to IDLE with no reply.
REQ-019 After 8 bits, the next low pulse (console stop bit) SHALL be accepted in RX_STOP; its rising edge ends the frame.
REQ-020 Command 0x00 SHALL reply 3 bytes: 0x05 0x00 0x02.
REQ-021 Command 0x01 SHALL reply 4 bytes: buttons[15:8], buttons[7:0], stick_x, stick_y.
REQ-022 Any other command SHALL get no reply and go to WAIT_IDLE (see REQ-033 for 0xFF).
REQ-023 Reply data SHALL be snapshotted on the stop-bit rising edge cycle; poll_strobe SHALL pulse in that same cycle for 0x01 only.
REQ-024 Input changes after the snapshot SHALL NOT affect the reply in flight.
REQ-025 TURN SHALL hold joy_oe=0 for 2*US_TICKS cycles before the first reply bit.
REQ-026 TX bit 0 SHALL be 3*US_TICKS low then 1*US_TICKS released; TX bit 1 SHALL be 1*US_TICKS low then 3*US_TICKS released.
REQ-027 TX_STOP SHALL be 2*US_TICKS low, then release and go to WAIT_IDLE.
REQ-028 WAIT_IDLE SHALL return to IDLE after IDLE_US*US_TICKS of continuous high; any low restarts the count.
REQ-029 Falling edges on joy_in while transmitting SHALL be ignored; the reply is never truncated.

Reset
REQ-030 While reset is high at a clk edge: state IDLE, joy_oe=0, poll_strobe=0, reset_cmd=0, busy=0, counters, shift and synchronizer registers cleared to 0.
REQ-031 Reset mid-transmit SHALL release the line (joy_oe=0) on the first reset cycle.
REQ-032 After reset, a frame already in progress SHALL NOT be decoded; the block enters RX only on a fresh falling edge seen after the synchronizer has filled with high.

Configuration
REQ-033 With JOYBUS_RESET_CMD_EN defined: 0xFF SHALL reply exactly like 0x00 and pulse reset_cmd at the stop-bit rising edge.
REQ-034 Without JOYBUS_RESET_CMD_EN: 0xFF SHALL be treated as unknown (no reply), and reset_cmd SHALL be tied 0.

Structure
REQ-035 Package n64_joybus_pkg SHALL hold the command codes (0x00, 0x01, 0xFF), the status bytes 0x05/0x00/0x02, and the state enum.
REQ-036 Sub-module joybus_bit_tx SHALL generate one TX bit or stop pulse from start/bit/is_stop inputs with a done output.

Verification (US_TICKS=4, IDLE_US=8)
REQ-037 Send 0x01 plus stop, buttons=0x9001, x=0x7F, y=0x80 -> poll_strobe pulses once; reply decodes to 90 01 7F 80 then a stop of 8 low cycles.
REQ-038 Send 0x00 -> reply 05 00 02; bit 0 measures 12 low/4 high cycles, bit 1 measures 4 low/12 high cycles.
REQ-039 Send 0xFF -> with the macro: reply 05 00 02 and a one-cycle reset_cmd; without it: joy_oe stays 0 and reset_cmd stays 0.
REQ-040 Send 5 bits then hold high for 33 cycles -> busy=0, no reply; a following 0x00 frame is answered normally.
REQ-041 Assert reset during the 2nd reply byte -> joy_oe=0 on the next cycle, all outputs at reset values.
REQ-042 Change buttons from 0x0000 to 0xFFFF during the 0x01 reply -> reply still carries 00 00.

Source files
------------

// File: rtl/n64_joybus_pkg.sv
// Shared definitions for the N64 joybus device: command codes, status reply
// bytes, timer width and the protocol state encoding.
package n64_joybus_pkg;

    localparam logic [7:0] CMD_INFO  = 8'h00;
    localparam logic [7:0] CMD_POLL  = 8'h01;
    localparam logic [7:0] CMD_RESET = 8'hFF;

    localparam logic [7:0] STATUS_B0 = 8'h05;
    localparam logic [7:0] STATUS_B1 = 8'h00;
    localparam logic [7:0] STATUS_B2 = 8'h02;

    // Status reply left-aligned in the 32-bit transmit shifter.
    localparam logic [31:0] STATUS_REPLY = {STATUS_B0, STATUS_B1, STATUS_B2, 8'h00};

    // Wide enough for IDLE_US*US_TICKS at realistic clock rates.
    localparam int TIMER_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        RX_LOW,
        RX_HIGH,
        RX_STOP,
        TURN,
        TX_LOW,
        TX_HIGH,
        TX_STOP,
        WAIT_IDLE
    } state_t;

endpackage

// File: rtl/n64_joybus_device_bit_tx.sv
// Single joybus symbol generator: one data bit (1/3 or 3/1 us low/high) or
// the 2 us device stop pulse. drive is high while the line must be pulled low.
module joybus_bit_tx
    import n64_joybus_pkg::*;
#(
    parameter int US_TICKS = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    input  logic is_stop,
    output logic drive,
    output logic released,
    output logic done
);

    localparam logic [TIMER_W-1:0] T1 = TIMER_W'(US_TICKS);
    localparam logic [TIMER_W-1:0] T2 = TIMER_W'(2 * US_TICKS);
    localparam logic [TIMER_W-1:0] T3 = TIMER_W'(3 * US_TICKS);
    localparam logic [TIMER_W-1:0] T4 = TIMER_W'(4 * US_TICKS);

    logic                active;
    logic [TIMER_W-1:0]  cnt;
    logic [TIMER_W-1:0]  low_len;
    logic [TIMER_W-1:0]  total_len;

    // Symbol timer: a new start always wins so symbols can run back to back.
    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= 1'b0;
            cnt       <= '0;
            low_len   <= '0;
            total_len <= '0;
        end else if (start) begin
            active    <= 1'b1;
            cnt       <= '0;
            low_len   <= is_stop ? T2 : (bit_val ? T1 : T3);
            total_len <= is_stop ? T2 : T4;
        end else if (active) begin
            if (cnt == total_len - TIMER_W'(1)) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + TIMER_W'(1);
            end
        end
    end

    assign drive    = active && (cnt < low_len);
    assign released = active && (cnt >= low_len);
    assign done     = active && (cnt == total_len - TIMER_W'(1));

endmodule

// File: rtl/n64_joybus_device.sv
// N64 controller-side joybus endpoint: decodes one console command byte and
// answers 0x00 (status) and 0x01 (poll) with open-drain reply frames.
// Optional: define JOYBUS_RESET_CMD_EN to answer 0xFF like 0x00 and pulse
// reset_cmd; otherwise 0xFF is ignored and reset_cmd is tied low.
module n64_joybus_device
    import n64_joybus_pkg::*;
#(
    parameter int US_TICKS = 50,
    parameter int IDLE_US  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        joy_in,
    output logic        joy_oe,
    input  logic [15:0] buttons,
    input  logic [7:0]  stick_x,
    input  logic [7:0]  stick_y,
    output logic        poll_strobe,
    output logic        reset_cmd,
    output logic        busy
);

    localparam logic [TIMER_W-1:0] T2         = TIMER_W'(2 * US_TICKS);
    localparam logic [TIMER_W-1:0] T2_LAST    = TIMER_W'(2 * US_TICKS - 1);
    localparam logic [TIMER_W-1:0] T5         = TIMER_W'(5 * US_TICKS);
    localparam logic [TIMER_W-1:0] IDLE_TICKS = TIMER_W'(IDLE_US * US_TICKS);
    localparam logic [TIMER_W-1:0] IDLE_LAST  = TIMER_W'(IDLE_US * US_TICKS - 1);

    state_t              state, state_next;
    logic                sync1, line, line_d;
    logic [TIMER_W-1:0]  timer;
    logic [3:0]          bit_cnt;
    logic [7:0]          cmd;
    logic [31:0]         tx_shift;
    logic [5:0]          bits_left;

    logic                timer_clr;
    logic                rx_shift;
    logic                snap_info;
    logic                snap_poll;
    logic                tx_start;
    logic                tx_is_stop;
    logic                tx_drive;
    logic                tx_released;
    logic                tx_done;
`ifdef JOYBUS_RESET_CMD_EN
    logic                reset_hit;
`endif

    // Synchronizer, state register, timers and the RX/TX shift registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            line      <= 1'b0;
            line_d    <= 1'b0;
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            cmd       <= '0;
            tx_shift  <= '0;
            bits_left <= '0;
        end else begin
            sync1  <= joy_in;
            line   <= sync1;
            line_d <= line;
            state  <= state_next;

            if (timer_clr) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + TIMER_W'(1);
            end

            if (state == IDLE && state_next == RX_LOW) begin
                cmd     <= '0;
                bit_cnt <= '0;
            end else if (rx_shift) begin
                cmd     <= {cmd[6:0], (timer < T2)};
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (snap_poll) begin
                tx_shift  <= {buttons, stick_x, stick_y};
                bits_left <= 6'd32;
            end else if (snap_info) begin
                tx_shift  <= STATUS_REPLY;
                bits_left <= 6'd24;
            end else if (tx_start && !tx_is_stop) begin
                tx_shift  <= {tx_shift[30:0], 1'b0};
                bits_left <= bits_left - 6'd1;
            end
        end
    end

    // Protocol next-state and per-cycle control strobes.
    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        rx_shift   = 1'b0;
        snap_info  = 1'b0;
        snap_poll  = 1'b0;
        tx_start   = 1'b0;
        tx_is_stop = 1'b0;
`ifdef JOYBUS_RESET_CMD_EN
        reset_hit  = 1'b0;
`endif
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (line_d && !line) begin
                    state_next = RX_LOW;
                end
            end
            RX_LOW: begin
                if (line) begin
                    rx_shift   = 1'b1;
                    timer_clr  = 1'b1;
                    state_next = RX_HIGH;
                end else if (timer >= T5) begin
                    timer_clr  = 1'b1;
                    state_next = WAIT_IDLE;
                end
            end
            RX_HIGH: begin
                if (!line) begin
                    timer_clr  = 1'b1;
                    state_next = (bit_cnt == 4'd8) ? RX_STOP : RX_LOW;
                end else if (timer >= IDLE_TICKS) begin
                    state_next = IDLE;
                end
            end
            RX_STOP: begin
                if (line) begin
                    timer_clr  = 1'b1;
                    state_next = WAIT_IDLE;
                    if (cmd == CMD_POLL) begin
                        snap_poll  = 1'b1;
                        state_next = TURN;
                    end else if (cmd == CMD_INFO) begin
                        snap_info  = 1'b1;
                        state_next = TURN;
                    end
`ifdef JOYBUS_RESET_CMD_EN
                    else if (cmd == CMD_RESET) begin
                        snap_info  = 1'b1;
                        reset_hit  = 1'b1;
                        state_next = TURN;
                    end
`endif
                end else if (timer >= T5) begin
                    timer_clr  = 1'b1;
                    state_next = WAIT_IDLE;
                end
            end
            TURN: begin
                if (timer == T2_LAST) begin
                    tx_start   = 1'b1;
                    state_next = TX_LOW;
                end
            end
            TX_LOW: begin
                if (tx_released) begin
                    state_next = TX_HIGH;
                end
            end
            TX_HIGH: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    if (bits_left == 6'd0) begin
                        tx_is_stop = 1'b1;
                        state_next = TX_STOP;
                    end else begin
                        state_next = TX_LOW;
                    end
                end
            end
            TX_STOP: begin
                if (tx_done) begin
                    timer_clr  = 1'b1;
                    state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!line) begin
                    timer_clr = 1'b1;
                end else if (timer >= IDLE_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    joybus_bit_tx #(
        .US_TICKS (US_TICKS)
    ) u_bit_tx (
        .clk      (clk),
        .reset    (reset),
        .start    (tx_start),
        .bit_val  (tx_shift[31]),
        .is_stop  (tx_is_stop),
        .drive    (tx_drive),
        .released (tx_released),
        .done     (tx_done)
    );

    assign joy_oe      = tx_drive;
    assign poll_strobe = snap_poll;
    assign busy        = (state != IDLE);
`ifdef JOYBUS_RESET_CMD_EN
    assign reset_cmd   = reset_hit;
`else
    assign reset_cmd   = 1'b0;
`endif

endmodule

// File: tb/tb_n64_joybus_device.sv
// Self-checking bench for n64_joybus_device (US_TICKS=4, IDLE_US=8).
// Expected 0xFF behaviour follows JOYBUS_RESET_CMD_EN when it is defined.
module tb_n64_joybus_device;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_low = 1'b0;
    logic        joy_in;
    logic        joy_oe;
    logic [15:0] buttons = 16'h0000;
    logic [7:0]  stick_x = 8'h00;
    logic [7:0]  stick_y = 8'h00;
    logic        poll_strobe;
    logic        reset_cmd;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int poll_cnt = 0;
    int rst_cnt = 0;
    int oe_cnt = 0;
    int lo_len[32];
    int hi_len[32];

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] buttons;
        logic [7:0]  sx;
        logic [7:0]  sy;
        int          nbytes;
        logic [31:0] reply;
        int          polls;
        int          resets;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    // Open-drain line: either side can pull it low.
    assign joy_in = ~(host_low | joy_oe);

    n64_joybus_device #(
        .US_TICKS (4),
        .IDLE_US  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .joy_in      (joy_in),
        .joy_oe      (joy_oe),
        .buttons     (buttons),
        .stick_x     (stick_x),
        .stick_y     (stick_y),
        .poll_strobe (poll_strobe),
        .reset_cmd   (reset_cmd),
        .busy        (busy)
    );

    // Pulse-width counters for the strobes and the line driver.
    always @(posedge clk) begin
        if (poll_strobe) poll_cnt++;
        if (reset_cmd)   rst_cnt++;
        if (joy_oe)      oe_cnt++;
    end

    // Hard stop if the bench itself ever stalls.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Console side: MSB-first bits, 1 = 1us low/3us high, 0 = 3us low/1us high.
    task automatic send_bits(input logic [7:0] val, input int nbits, input bit with_stop);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = val[7 - i];
            host_low = 1'b1;
            repeat (b ? 4 : 12) tick();
            host_low = 1'b0;
            repeat (b ? 12 : 4) tick();
        end
        if (with_stop) begin
            host_low = 1'b1;
            repeat (4) tick();
            host_low = 1'b0;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        buttons = v.buttons;
        stick_x = v.sx;
        stick_y = v.sy;
        send_bits(v.cmd, 8, 1'b1);
    endtask

    // Decode the device reply from joy_oe, logging per-bit low/high widths.
    task automatic capture(input int nbytes, input bit glitch, output logic [31:0] data,
                           output int stop_len, output int ok);
        int t;
        int lo;
        int hi;
        data = '0;
        stop_len = 0;
        ok = 0;
        t = 0;
        while (!joy_oe && t < 100) begin
            tick();
            t++;
        end
        if (joy_oe) begin
            ok = 1;
            if (glitch) buttons = 16'hFFFF;
            for (int i = 0; i < nbytes * 8; i++) begin
                lo = 0;
                while (joy_oe && lo < 40) begin tick(); lo++; end
                hi = 0;
                while (!joy_oe && hi < 40) begin tick(); hi++; end
                lo_len[i] = lo;
                hi_len[i] = hi;
                data = {data[30:0], (lo < 8)};
            end
            lo = 0;
            while (joy_oe && lo < 40) begin tick(); lo++; end
            stop_len = lo;
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 300) begin
            tick();
            t++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    logic [31:0] data;
    int          stop_len;
    int          ok;
    int          p0;
    int          r0;
    int          o0;
    int          rises;
    logic        prev_oe;

    initial begin
        vecs[0] = '{8'h01, 16'h9001, 8'h7F, 8'h80, 4, 32'h90017F80, 1, 0};
        vecs[1] = '{8'h00, 16'h1234, 8'h00, 8'h00, 3, 32'h00050002, 0, 0};
        vecs[2] = '{8'h01, 16'hA5C3, 8'h01, 8'hFF, 4, 32'hA5C301FF, 1, 0};
`ifdef JOYBUS_RESET_CMD_EN
        vecs[3] = '{8'hFF, 16'h0000, 8'h00, 8'h00, 3, 32'h00050002, 0, 1};
`else
        vecs[3] = '{8'hFF, 16'h0000, 8'h00, 8'h00, 0, 32'h00000000, 0, 0};
`endif
        vecs[4] = '{8'h02, 16'hFFFF, 8'h00, 8'h00, 0, 32'h00000000, 0, 0};
        vecs[5] = '{8'h80, 16'hFFFF, 8'h00, 8'h00, 0, 32'h00000000, 0, 0};

        // Reset with the line held low: releasing it must not start a frame.
        reset = 1'b1;
        host_low = 1'b1;
        repeat (3) tick();
        checkOutput("reset_joy_oe", 32'(joy_oe), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_poll_strobe", 32'(poll_strobe), 32'd0);
        checkOutput("reset_reset_cmd", 32'(reset_cmd), 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        checkOutput("low_after_reset_busy", 32'(busy), 32'd0);
        host_low = 1'b0;
        repeat (40) tick();
        checkOutput("release_after_reset_busy", 32'(busy), 32'd0);

        // Table-driven command frames.
        for (int i = 0; i < 6; i++) begin
            p0 = poll_cnt;
            r0 = rst_cnt;
            o0 = oe_cnt;
            $display("[TB] vector %0d cmd 0x%02h", i, vecs[i].cmd);
            applyStimulus(vecs[i]);
            if (vecs[i].nbytes > 0) begin
                capture(vecs[i].nbytes, 1'b0, data, stop_len, ok);
                checkOutput($sformatf("v%0d_reply_seen", i), 32'(ok), 32'd1);
                checkOutput($sformatf("v%0d_reply", i), data, vecs[i].reply);
                checkOutput($sformatf("v%0d_stop_len", i), 32'(stop_len), 32'd8);
                if (i == 1) begin
                    checkOutput("bit0_low", 32'(lo_len[0]), 32'd12);
                    checkOutput("bit0_high", 32'(hi_len[0]), 32'd4);
                    checkOutput("bit1_low", 32'(lo_len[5]), 32'd4);
                    checkOutput("bit1_high", 32'(hi_len[5]), 32'd12);
                end
            end else begin
                repeat (60) tick();
                checkOutput($sformatf("v%0d_no_reply_oe", i), 32'(oe_cnt - o0), 32'd0);
            end
            wait_idle($sformatf("v%0d_idle", i));
            checkOutput($sformatf("v%0d_poll_pulses", i), 32'(poll_cnt - p0), 32'(vecs[i].polls));
            checkOutput($sformatf("v%0d_reset_cmd_pulses", i), 32'(rst_cnt - r0), 32'(vecs[i].resets));
        end

        // Partial frame: 5 bits then a long high aborts without a reply.
        o0 = oe_cnt;
        send_bits(8'h00, 5, 1'b0);
        repeat (35) tick();
        checkOutput("partial_busy", 32'(busy), 32'd0);
        repeat (20) tick();
        checkOutput("partial_no_reply", 32'(oe_cnt - o0), 32'd0);
        send_bits(8'h00, 8, 1'b1);
        capture(3, 1'b0, data, stop_len, ok);
        checkOutput("after_partial_reply", data, 32'h00050002);
        wait_idle("after_partial_idle");

        // Snapshot isolation: buttons change while the poll reply is in flight.
        buttons = 16'h0000;
        stick_x = 8'h11;
        stick_y = 8'h22;
        send_bits(8'h01, 8, 1'b1);
        capture(4, 1'b1, data, stop_len, ok);
        checkOutput("snapshot_reply", data, 32'h00001122);
        wait_idle("snapshot_idle");

        // Reset during the second reply byte must release the line at once.
        buttons = 16'hFFFF;
        send_bits(8'h01, 8, 1'b1);
        rises = 0;
        prev_oe = 1'b0;
        for (int t = 0; t < 600 && rises < 10; t++) begin
            tick();
            if (joy_oe && !prev_oe) rises++;
            prev_oe = joy_oe;
        end
        checkOutput("midtx_reached_byte2", 32'(rises), 32'd10);
        reset = 1'b1;
        tick();
        checkOutput("midtx_reset_joy_oe", 32'(joy_oe), 32'd0);
        checkOutput("midtx_reset_busy", 32'(busy), 32'd0);
        checkOutput("midtx_reset_poll_strobe", 32'(poll_strobe), 32'd0);
        checkOutput("midtx_reset_reset_cmd", 32'(reset_cmd), 32'd0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        send_bits(8'h00, 8, 1'b1);
        capture(3, 1'b0, data, stop_len, ok);
        checkOutput("after_reset_reply", data, 32'h00050002);
        wait_idle("after_reset_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
